// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshaking.
//
// Stage 1 captures the operands and opcode of an accepted transaction.
// Stage 2 evaluates the operation and registers result, flags and error.
// A result held at the output (out_valid && !out_ready) stays frozen until
// it is taken; stage 1 keeps accepting while stage 2 is free or draining.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    upstream transaction valid
//   in_ready    block can accept a transaction this cycle
//   in_a        operand A (WIDTH bits)
//   in_b        operand B, low SHW bits also give the shift amount
//   in_op       opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR,
//               7 SRA, 8 SLT, 9 SLTU; 10..15 illegal
//   out_valid   result valid
//   out_ready   downstream accepts result
//   out_result  result (WIDTH bits)
//   out_flags   {C, V, N, Z}
//   out_err     result came from an illegal opcode
//
// Parameters
//   WIDTH       operand/result width: 8, 16, 32 or 64
//   SATURATE    1 = signed ADD/SUB results clamp on overflow

module alu_pipe #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------
  // Stage 1: operand registers
  // ---------------------------------------------------------------------
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;

  logic accept;
  logic advance;

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Stage 2 can take a new result when empty or when its current one leaves.
  assign advance  = s1_valid && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_op    <= in_op;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 datapath (combinational, from stage-1 registers)
  // ---------------------------------------------------------------------
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   sra_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt_signed;
  logic             lt_unsigned;

  assign shamt   = s1_b[SHW-1:0];
  assign add_ext = {1'b0, s1_a} + {1'b0, s1_b};
  // Top bit of the extended difference is the unsigned borrow (a < b).
  assign sub_ext = {1'b0, s1_a} - {1'b0, s1_b};

  // One guard bit on the side bits leave from captures the last bit shifted
  // out; with a zero amount the guard bit stays 0.
  assign shl_ext = {1'b0, s1_a} << shamt;
  assign shr_ext = {s1_a, 1'b0} >> shamt;
  assign sra_ext = $signed({s1_a, 1'b0}) >>> shamt;

  assign add_ovf = (s1_a[MSB] == s1_b[MSB]) && (add_ext[MSB] != s1_a[MSB]);
  assign sub_ovf = (s1_a[MSB] != s1_b[MSB]) && (sub_ext[MSB] != s1_a[MSB]);

  assign lt_signed   = $signed(s1_a) < $signed(s1_b);
  assign lt_unsigned = s1_a < s1_b;

  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;
  logic             n_d;
  logic             z_d;
  logic             err_d;

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    err_d = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_d = add_ext[WIDTH-1:0];
        c_d   = add_ext[WIDTH];
        v_d   = add_ovf;
      end
      OP_SUB: begin
        res_d = sub_ext[WIDTH-1:0];
        c_d   = sub_ext[WIDTH];
        v_d   = sub_ovf;
      end
      OP_AND: res_d = s1_a & s1_b;
      OP_OR:  res_d = s1_a | s1_b;
      OP_XOR: res_d = s1_a ^ s1_b;
      OP_SHL: begin
        res_d = shl_ext[WIDTH-1:0];
        c_d   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_d = shr_ext[WIDTH:1];
        c_d   = shr_ext[0];
      end
      OP_SRA: begin
        res_d = sra_ext[WIDTH:1];
        c_d   = sra_ext[0];
      end
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default: err_d = 1'b1;
    endcase

    // Clamp towards the sign of A: an overflowing signed ADD/SUB always
    // leaves the range on the side A sits on.
    if ((SATURATE != 0) && v_d && ((s1_op == OP_ADD) || (s1_op == OP_SUB))) begin
      res_d = s1_a[MSB] ? SIGNED_MIN : SIGNED_MAX;
    end
  end

  // N and Z come from the final result so saturation is reflected.
  assign n_d = res_d[MSB];
  assign z_d = (res_d == '0);

  // ---------------------------------------------------------------------
  // Stage 2: result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_err    <= 1'b0;
    end else begin
      if (advance) begin
        out_valid  <= 1'b1;
        out_result <= res_d;
        out_flags  <= {c_d, v_d, n_d, z_d};
        out_err    <= err_d;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [3:0]    in_op = '0;
  logic          out_ready = 1'b1;

  logic          in_ready0, in_ready1;
  logic          out_valid0, out_valid1;
  logic [W-1:0]  out_result0, out_result1;
  logic [3:0]    out_flags0, out_flags1;
  logic          out_err0, out_err1;

  alu_pipe #(.WIDTH(W), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid0),
    .out_ready(out_ready), .out_result(out_result0), .out_flags(out_flags0),
    .out_err(out_err0)
  );

  alu_pipe #(.WIDTH(W), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid1),
    .out_ready(out_ready), .out_result(out_result1), .out_flags(out_flags1),
    .out_err(out_err1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_count = 0;

  // expected entry: {err, C, V, N, Z, result[15:0]}
  logic [20:0] exp0_q[$];
  logic [20:0] exp1_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input bit sat);
    int ua, ub, sa, sb, sr, r, amt;
    bit c, v, n, z, err;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    amt = b[3:0];
    c = 0; v = 0; err = 0; r = 0;
    case (op)
      4'd0: begin
        r = ua + ub; c = (r > 65535);
        sr = sa + sb; v = (sr > 32767) || (sr < -32768);
      end
      4'd1: begin
        r = ua - ub; c = (ua < ub);
        sr = sa - sb; v = (sr > 32767) || (sr < -32768);
      end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: begin
        r = ua << amt;
        c = (amt != 0) && (((ua >> (16 - amt)) & 1) != 0);
      end
      4'd6: begin
        r = ua >> amt;
        c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
      end
      4'd7: begin
        r = sa >>> amt;
        c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
      end
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: r = (ua < ub) ? 1 : 0;
      default: begin r = 0; err = 1; end
    endcase
    r = r & 32'hFFFF;
    if (sat && v && (op <= 4'd1)) r = (sa >= 0) ? 32'h7FFF : 32'h8000;
    n = ((r >> 15) & 1) != 0;
    z = (r == 0);
    return {err, c, v, n, z, r[15:0]};
  endfunction

  // Acceptance monitor: handshake seen before the edge that completes it.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready0) begin
      exp0_q.push_back(model(in_a, in_b, in_op, 1'b0));
      exp1_q.push_back(model(in_a, in_b, in_op, 1'b1));
      acc_count++;
    end
  end

  // Output monitor: scoreboard pop on transfer, plus hold-stability check.
  logic        held = 1'b0;
  logic [20:0] held0, held1;
  logic [20:0] e0, e1;

  always @(negedge clk) begin
    if (held && out_valid0) begin
      chk("stall_hold0", {out_err0, out_flags0, out_result0}, held0);
      chk("stall_hold1", {out_err1, out_flags1, out_result1}, held1);
    end
    if (out_valid0 && out_ready) begin
      if (exp0_q.size() == 0 || exp1_q.size() == 0) begin
        chk("unexpected_output", 64'(out_valid0), 64'd0);
      end else begin
        e0 = exp0_q.pop_front();
        e1 = exp1_q.pop_front();
        chk("result_sat0", {out_err0, out_flags0, out_result0}, e0);
        chk("result_sat1", {out_err1, out_flags1, out_result1}, e1);
      end
    end
    held  = out_valid0 && !out_ready;
    held0 = {out_err0, out_flags0, out_result0};
    held1 = {out_err1, out_flags1, out_result1};
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    forever begin
      @(negedge clk);
      if (in_ready0) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Single op on an idle pipeline: checks 2-cycle latency and known values.
  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic [15:0] r0, input logic [3:0] f0,
                         input logic [15:0] r1, input logic [3:0] f1, input logic err);
    sync();
    out_ready = 1'b1;
    send(a, b, op);
    @(negedge clk);
    chk({name, "_valid_early"}, 64'(out_valid0), 64'd0);
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid0), 64'd1);
    chk({name, "_sat0"}, {out_err0, out_flags0, out_result0}, {err, f0, r0});
    chk({name, "_sat1"}, {out_err1, out_flags1, out_result1}, {err, f1, r1});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp0_q.size() != 0 || out_valid0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp0_q.size()), 64'd0);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'h0001;
      2: v = 16'h7FFF;
      3: v = 16'h8000;
      4: v = 16'hFFFF;
      default: v = 16'($urandom_range(0, 65535));
    endcase
    return v;
  endfunction

  bit rand_done = 0;
  bit burst_done = 0;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;
    // Reset state
    #2;
    chk("reset_in_ready", 64'(in_ready0), 64'd1);
    chk("reset_outputs", {out_valid0, out_err0, out_flags0, out_result0}, 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready0), 64'd1);

    // Directed values
    run_one("add_ovf", 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b0110, 16'h7FFF, 4'b0100, 1'b0);
    run_one("sub_borrow", 16'h0000, 16'h0001, 4'd1, 16'hFFFF, 4'b1010, 16'hFFFF, 4'b1010, 1'b0);
    run_one("sub_zero", 16'h1234, 16'h1234, 4'd1, 16'h0000, 4'b0001, 16'h0000, 4'b0001, 1'b0);
    run_one("sra", 16'h8000, 16'h0013, 4'd7, 16'hF000, 4'b0010, 16'hF000, 4'b0010, 1'b0);
    run_one("shl", 16'h8001, 16'h0001, 4'd5, 16'h0002, 4'b1000, 16'h0002, 4'b1000, 1'b0);
    run_one("shr_zero_amt", 16'hA5A5, 16'h0010, 4'd6, 16'hA5A5, 4'b0010, 16'hA5A5, 4'b0010, 1'b0);
    run_one("sub_sat_neg", 16'h8000, 16'h0001, 4'd1, 16'h7FFF, 4'b0100, 16'h8000, 4'b0110, 1'b0);
    run_one("illegal", 16'hFFFF, 16'h0000, 4'hC, 16'h0000, 4'b0001, 16'h0000, 4'b0001, 1'b1);
    run_one("after_illegal", 16'hFFFF, 16'h0F0F, 4'd2, 16'h0F0F, 4'b0000, 16'h0F0F, 4'b0000, 1'b0);
    run_one("slt", 16'hFFFF, 16'h0001, 4'd8, 16'h0001, 4'b0000, 16'h0001, 4'b0000, 1'b0);
    run_one("sltu", 16'hFFFF, 16'h0001, 4'd9, 16'h0000, 4'b0001, 16'h0000, 4'b0001, 1'b0);
    drain("drain_directed");

    // Back-to-back stream against a stalled output
    sync();
    out_ready = 1'b0;
    base = acc_count;
    burst_done = 0;
    fork
      begin
        send(16'h0003, 16'h0004, 4'd0);
        send(16'h00F0, 16'h000F, 4'd3);
        send(16'h0001, 16'h0004, 4'd5);
        send(16'h0010, 16'h0011, 4'd1);
        burst_done = 1;
      end
    join_none
    repeat (5) @(negedge clk);
    chk("stall_accepts", 64'(acc_count - base), 64'd2);
    chk("stall_in_ready", 64'(in_ready0), 64'd0);
    chk("stall_out_valid", 64'(out_valid0), 64'd1);
    sync();
    out_ready = 1'b1;
    seen = 0;
    while (!burst_done && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    chk("burst_sent", 64'(burst_done), 64'd1);
    drain("drain_burst");

    // Reset with both stages full
    sync();
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 4'd0);
    send(16'h3333, 16'h4444, 4'd4);
    #2;
    chk("pre_reset_valid", 64'(out_valid0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid0), 64'd0);
    chk("async_reset_regs", {in_ready0, out_err0, out_flags0, out_result0}, {1'b1, 21'd0});
    exp0_q.delete();
    exp1_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid0) seen++;
    end
    chk("no_stale_after_reset", 64'(seen), 64'd0);
    run_one("post_reset_op", 16'h0005, 16'h0003, 4'd1, 16'h0002, 4'b0000, 16'h0002, 4'b0000, 1'b0);
    drain("drain_reset");

    // Randomized traffic with random backpressure
    sync();
    rand_done = 0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(10, 15));
      else op = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) sync();
      send(pick_operand(), pick_operand(), op);
    end
    rand_done = 1;
    repeat (2) sync();
    out_ready = 1'b1;
    drain("drain_random");
    chk("total_accepts_nonzero", 64'(acc_count > 400), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
